// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - shared lamp-count constant and shift-stage state type
package bound_flasher_pkg;

    localparam int LAMP_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } shift_state_t;

endpackage

// File: rtl/shift_tick_counter.sv
// rtl/shift_tick_counter.sv - per-state cycle divider, ticks on the last of CLK_DIV cycles
module shift_tick_counter #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == TERM);

    // Wrapping on tick restarts the count in step with every tick-driven state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// rtl/led_shift_driver.sv - serialises the lamp vector into a 74HC595-style shift register
module led_shift_driver
    import bound_flasher_pkg::*;
#(
    parameter int WIDTH     = LAMP_WIDTH,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] light,
    input  logic             refresh,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? BW'(WIDTH - 1) : BW'(0);
    localparam logic [BW-1:0] LAST_IDX  = (MSB_FIRST != 0) ? BW'(0) : BW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || CLK_DIV < 1) begin : g_bad_params
            $error("led_shift_driver: WIDTH and CLK_DIV must both be >= 1");
        end
    endgenerate

    shift_state_t     state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] last_sent_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [BW-1:0]    bit_cnt_d;
    logic             refresh_pend_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             latch_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             tick;
    logic             start;

    // Holding the divider cleared in IDLE makes every frame's first phase a full CLK_DIV.
    shift_tick_counter #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear_i(state_q == IDLE),
        .tick_o (tick)
    );

    assign start     = (light != last_sent_q) || refresh_pend_q || refresh;
    assign bit_cnt_d = (MSB_FIRST != 0) ? (bit_cnt_q - BW'(1)) : (bit_cnt_q + BW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            last_sent_q    <= '0;
            bit_cnt_q      <= '0;
            refresh_pend_q <= 1'b1;
            sclk_q         <= 1'b0;
            sdata_q        <= 1'b0;
            latch_q        <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (refresh) begin
                refresh_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q       <= light;
                        bit_cnt_q      <= FIRST_IDX;
                        sdata_q        <= light[FIRST_IDX];
                        busy_q         <= 1'b1;
                        refresh_pend_q <= 1'b0;
                        state_q        <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sclk_q <= 1'b0;
                        if (bit_cnt_q == LAST_IDX) begin
                            sdata_q <= 1'b0;
                            latch_q <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                            sdata_q   <= shadow_q[bit_cnt_d];
                            state_q   <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        latch_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        last_sent_q  <= shadow_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// tb/tb_led_shift_driver.sv - scoreboard bench for two driver configurations
module tb_led_shift_driver;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn    [2];
    logic [W-1:0] light   [2];
    logic         refresh [2];
    logic         sclk    [2];
    logic         sdata   [2];
    logic         latch   [2];
    logic         busy    [2];
    logic         fdone   [2];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int frames_exp  [2] = '{0, 0};
    int frames_seen [2] = '{0, 0};
    bit done1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int CD    = (g == 0) ? 4 : 1;
        localparam int MF    = (g == 0) ? 1 : 0;
        localparam int FRAME = (2 * W + 1) * CD;

        typedef struct {
            logic [W-1:0] data;
            int           start;
        } exp_t;

        led_shift_driver #(
            .WIDTH(W), .CLK_DIV(CD), .MSB_FIRST(MF)
        ) dut (
            .clk       (clk),
            .reset_n   (rstn[g]),
            .light     (light[g]),
            .refresh   (refresh[g]),
            .sclk      (sclk[g]),
            .sdata     (sdata[g]),
            .latch     (latch[g]),
            .busy      (busy[g]),
            .frame_done(fdone[g])
        );

        // Reference: a frame begins whenever the link is free and the image differs or a refresh waits.
        exp_t         q[$];
        logic [W-1:0] m_last;
        bit           m_pend;
        int           m_free;

        always @(posedge clk or negedge rstn[g]) begin
            if (!rstn[g]) begin
                frames_exp[g] -= q.size();
                q.delete();
                m_last = '0;
                m_pend = 1'b1;
                m_free = 0;
            end else begin
                if (refresh[g]) m_pend = 1'b1;
                if (cyc >= m_free && (light[g] != m_last || m_pend)) begin
                    q.push_back('{data: light[g], start: cyc});
                    m_last = light[g];
                    m_pend = 1'b0;
                    m_free = cyc + FRAME + 1;
                    frames_exp[g]++;
                end
            end
        end

        bit           p_sclk, p_latch, p_busy;
        int           k, start_e, latch_e, e;
        logic [W-1:0] rx;
        exp_t         item;

        always @(negedge clk) begin
            e = cyc - 1;
            if (!rstn[g]) begin
                p_sclk = 0; p_latch = 0; p_busy = 0; k = 0;
            end else begin
                if (busy[g] && !p_busy) begin
                    k = 0; rx = '0; start_e = e;
                    if (q.size() == 0) check($sformatf("g%0d_unexpected_start", g), e, -1);
                    else check($sformatf("g%0d_start_edge", g), e, q[0].start);
                end
                if (sclk[g] && !p_sclk) begin
                    check($sformatf("g%0d_sclk_rise_%0d", g, k), e, start_e + (2 * k + 1) * CD);
                    if (k < W) rx[(MF != 0) ? (W - 1 - k) : k] = sdata[g];
                    k++;
                end
                if (latch[g] && !p_latch) begin
                    latch_e = e;
                    check($sformatf("g%0d_latch_edge", g), e, start_e + 2 * W * CD);
                    check($sformatf("g%0d_latch_sdata", g), sdata[g], 0);
                end
                if (fdone[g]) begin
                    check($sformatf("g%0d_bit_count", g), k, W);
                    check($sformatf("g%0d_latch_len", g), e - latch_e, CD);
                    check($sformatf("g%0d_done_edge", g), e, start_e + FRAME);
                    check($sformatf("g%0d_busy_at_done", g), busy[g], 0);
                    if (q.size() == 0) begin
                        check($sformatf("g%0d_spurious_done", g), 1, 0);
                    end else begin
                        item = q.pop_front();
                        check($sformatf("g%0d_frame_data", g), rx, item.data);
                    end
                    frames_seen[g]++;
                end
                p_sclk = sclk[g]; p_latch = latch[g]; p_busy = busy[g];
            end
        end
    end

    task automatic pulse_refresh(input int g);
        refresh[g] = 1'b1;
        @(negedge clk);
        refresh[g] = 1'b0;
    endtask

    task automatic wait_quiet(input int g, input int budget);
        int calm = 0;
        for (int i = 0; i < budget && calm < 3; i++) begin
            @(negedge clk);
            if (!busy[g] && frames_exp[g] == frames_seen[g]) calm++;
            else calm = 0;
        end
        if (calm < 3) check($sformatf("g%0d_quiet_timeout", g), 0, 1);
    endtask

    task automatic wait_busy(input int g, input int budget);
        int i = 0;
        while (!busy[g] && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!busy[g]) check($sformatf("g%0d_busy_timeout", g), 0, 1);
    endtask

    task automatic check_outputs_zero(input int g, input string tag);
        check($sformatf("g%0d_%s_sclk", g, tag), sclk[g], 0);
        check($sformatf("g%0d_%s_sdata", g, tag), sdata[g], 0);
        check($sformatf("g%0d_%s_latch", g, tag), latch[g], 0);
        check($sformatf("g%0d_%s_busy", g, tag), busy[g], 0);
        check($sformatf("g%0d_%s_done", g, tag), fdone[g], 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Second configuration: LSB first, one-cycle phases.
    initial begin
        rstn[1] = 1'b0; light[1] = '0; refresh[1] = 1'b0;
        repeat (3) @(negedge clk);
        rstn[1] = 1'b1;
        wait_quiet(1, 200);
        light[1] = 16'h8001;
        wait_quiet(1, 200);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: light[1] = W'($urandom);
                1: pulse_refresh(1);
                default: light[1] = light[1] ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_quiet(1, 500);
        done1 = 1'b1;
    end

    initial begin
        int base;
        int rises;
        bit ps;
        rstn[0] = 1'b0; light[0] = '0; refresh[0] = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero(0, "reset");
        check_outputs_zero(1, "reset");
        @(negedge clk);
        @(negedge clk);
        rstn[0] = 1'b1;

        wait_quiet(0, 400);
        check("forced_frame_count", frames_seen[0], 1);
        repeat (300) @(negedge clk);
        check("stable_no_frames", frames_seen[0], 1);

        light[0] = 16'h001F;
        wait_quiet(0, 400);
        check("frame_001f_count", frames_seen[0], 2);

        base = frames_seen[0];
        light[0] = 16'h0001;
        wait_busy(0, 10);
        repeat (20) @(negedge clk);
        light[0] = 16'h0003;
        repeat (40) @(negedge clk);
        light[0] = 16'h0007;
        wait_quiet(0, 600);
        check("midframe_change_frames", frames_seen[0] - base, 2);

        base = frames_seen[0];
        pulse_refresh(0);
        wait_quiet(0, 400);
        check("idle_refresh_frames", frames_seen[0] - base, 1);

        base = frames_seen[0];
        pulse_refresh(0);
        wait_busy(0, 10);
        repeat (10) @(negedge clk);
        pulse_refresh(0);
        repeat (15) @(negedge clk);
        pulse_refresh(0);
        wait_quiet(0, 800);
        check("double_refresh_frames", frames_seen[0] - base, 2);

        base = frames_seen[0];
        pulse_refresh(0);
        rises = 0; ps = 1'b0;
        for (int i = 0; i < 300 && rises < 5; i++) begin
            @(negedge clk);
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
        end
        check("reset_test_rises", rises, 5);
        #2;
        rstn[0] = 1'b0;
        #1;
        check_outputs_zero(0, "async_reset");
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        wait_quiet(0, 400);
        check("reset_abandon_frames", frames_seen[0] - base, 1);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0: light[0] = W'($urandom);
                1: pulse_refresh(0);
                2: ;
                default: light[0] = light[0] ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        wait_quiet(0, 800);

        for (int i = 0; i < 20000 && !done1; i++) @(negedge clk);
        check("cfg1_finished", done1, 1);
        check("g0_frames_balance", frames_seen[0], frames_exp[0]);
        check("g1_frames_balance", frames_seen[1], frames_exp[1]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
